// File: rtl/adder_tree_accum.sv
// Pipelined signed adder tree over N channels feeding a block accumulator with decimated output.
// Latency: LOGN+1 cycles through the tree, LOGN+2 cycles from the last sample's din_valid to dout_valid.
// No backpressure: accepts a sample on every din_valid; bubbles hold state. Macro ADDER_TREE_ACCUM_SAT_EN selects saturation.

// Recursive tree node: registers every level, delay-balances the shorter branch.
module adder_tree_accum_node #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW*N-1:0]         din,
  output logic [DW+$clog2(N)-1:0] sum_o
);
  localparam int SW = DW + $clog2(N);

  logic [SW-1:0] sum_q;
  assign sum_o = sum_q;

  generate
    if (N == 1) begin : g_leaf
      // Leaf register: a single channel still costs one pipeline stage
      always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= din;
      end
    end else begin : g_split
      localparam int NT = N - N/2;
      localparam int NB = N/2;
      localparam int TW = DW + $clog2(NT);
      localparam int BW = DW + $clog2(NB);
      // Bottom branch can be one level shallower than the top one
      localparam int D  = $clog2(NT) - $clog2(NB);

      logic [TW-1:0] top_sum;
      logic [BW-1:0] bot_sum;
      logic [BW-1:0] bot_dly;

      adder_tree_accum_node #(.DW(DW), .N(NT)) u_top (
        .clk   (clk),
        .rst   (rst),
        .din   (din[DW*N-1 -: DW*NT]),
        .sum_o (top_sum)
      );

      adder_tree_accum_node #(.DW(DW), .N(NB)) u_bot (
        .clk   (clk),
        .rst   (rst),
        .din   (din[DW*NB-1:0]),
        .sum_o (bot_sum)
      );

      if (D == 0) begin : g_nobal
        assign bot_dly = bot_sum;
      end else begin : g_bal
        logic [BW-1:0] dly_q [D];
        // Balancing delay line so both halves of one sample meet at this adder
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int i = 0; i < D; i++) dly_q[i] <= '0;
          end else begin
            dly_q[0] <= bot_sum;
            for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
          end
        end
        assign bot_dly = dly_q[D-1];
      end

      // Sign-extend both branches to this node's width and add; no node can wrap
      always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= {{(SW-TW){top_sum[TW-1]}}, top_sum}
                        + {{(SW-BW){bot_dly[BW-1]}}, bot_dly};
      end
    end
  endgenerate
endmodule

module adder_tree_accum #(
  parameter int DW        = 16,
  parameter int N         = 4,
  parameter int ACC_LEN_W = 8,
  parameter int OW        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW*N-1:0]      din,
  input  logic                 din_valid,
  input  logic [ACC_LEN_W-1:0] acc_len,
  input  logic                 clear,
  output logic [OW-1:0]        dout,
  output logic                 dout_valid,
  output logic                 overflow
);
  localparam int LOGN = $clog2(N);
  localparam int TW   = DW + LOGN;
  localparam int AW   = DW + LOGN + ACC_LEN_W;

  logic [TW-1:0]        tsum;
  logic [LOGN:0]        vld_q;
  logic                 tv;
  logic [AW-1:0]        acc_q, acc_d;
  logic [ACC_LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_LEN_W-1:0] len_q, len_d;
  logic [OW-1:0]        dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 ovf_q, ovf_d;
  logic                 first;
  logic                 last;
  logic [ACC_LEN_W-1:0] cnt_cur;
  logic [ACC_LEN_W-1:0] len_cur;
  logic [AW-1:0]        sum_d;
  logic [OW-1:0]        fmt_val;
  logic                 sat_hit;

  adder_tree_accum_node #(.DW(DW), .N(N)) u_tree (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sum_o (tsum)
  );

  // Valid bit travels alongside the tree data, one stage per tree level
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= din_valid;
      for (int i = 1; i <= LOGN; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  assign tv = vld_q[LOGN];

  // clear makes the incoming tree sample the start of a fresh block
  assign first   = clear || (cnt_q == '0);
  assign cnt_cur = first ? '0 : cnt_q;
  assign len_cur = first ? acc_len : len_q;
  assign last    = (cnt_cur == len_cur);
  assign sum_d   = (first ? '0 : acc_q) + {{ACC_LEN_W{tsum[TW-1]}}, tsum};

  generate
    if (OW > AW) begin : g_ext
      assign fmt_val = {{(OW-AW){sum_d[AW-1]}}, sum_d};
      assign sat_hit = 1'b0;
    end else if (OW == AW) begin : g_same
      assign fmt_val = sum_d;
      assign sat_hit = 1'b0;
    end else begin : g_narrow
`ifdef ADDER_TREE_ACCUM_SAT_EN
      // Out of range when the bits above the output sign bit disagree with it
      assign sat_hit = !((&sum_d[AW-1:OW-1]) || !(|sum_d[AW-1:OW-1]));
      assign fmt_val = !sat_hit   ? sum_d[OW-1:0] :
                       sum_d[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
      assign fmt_val = sum_d[OW-1:0];
      assign sat_hit = 1'b0;
`endif
    end
  endgenerate

  // Block accumulator: bubbles hold, last sample of a block emits one strobe
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    ovf_d  = clear ? 1'b0 : ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (tv) begin
      if (last) begin
        acc_d  = '0;
        cnt_d  = '0;
        dout_d = fmt_val;
        dv_d   = 1'b1;
        ovf_d  = ovf_d | sat_hit;
      end else begin
        acc_d = sum_d;
        cnt_d = cnt_cur + ACC_LEN_W'(1);
        len_d = len_cur;
      end
    end
  end

  // Accumulator and output state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_adder_tree_accum.sv
// Bench for adder_tree_accum: three instances (N=4/OW=32, N=3/OW=32, N=4/OW=16) share control inputs.
// Expected block sums and strobe cycles are queued when stimulus is driven, popped when dout_valid fires.
// Build with ADDER_TREE_ACCUM_SAT_EN defined to check the saturating variant.
module tb_adder_tree_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        clear;
  logic [7:0]  acc_len;
  logic [63:0] din_a, din_c;
  logic [47:0] din_b;
  logic [31:0] dout_a, dout_b;
  logic [15:0] dout_c;
  logic        dv_a, dv_b, dv_c;
  logic        ovf_a, ovf_b, ovf_c;

  logic signed [15:0] ch_a [4];
  logic signed [15:0] ch_b [3];
  logic signed [15:0] ch_c [4];

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  exp_t   q_a [$];
  exp_t   q_b [$];
  exp_t   q_c [$];
  int     m_cnt [3];
  int     m_len [3];
  longint m_acc [3];
  bit     m_ovf;
  int     cyc   = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_tree_accum #(.DW(16), .N(4), .ACC_LEN_W(8), .OW(32)) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid), .acc_len(acc_len),
    .clear(clear), .dout(dout_a), .dout_valid(dv_a), .overflow(ovf_a));

  adder_tree_accum #(.DW(16), .N(3), .ACC_LEN_W(8), .OW(32)) u_dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid), .acc_len(acc_len),
    .clear(clear), .dout(dout_b), .dout_valid(dv_b), .overflow(ovf_b));

  adder_tree_accum #(.DW(16), .N(4), .ACC_LEN_W(8), .OW(16)) u_dut_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(din_valid), .acc_len(acc_len),
    .clear(clear), .dout(dout_c), .dout_valid(dv_c), .overflow(ovf_c));

  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int idx, input longint v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    case (idx)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int idx, input logic dv, input longint act);
    exp_t e;
    bit   have;
    if (dv) begin
      have = 1'b0;
      case (idx)
        0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        chk($sformatf("spurious_dv%0d", idx), 1, 0);
      end else begin
        chk($sformatf("dout%0d", idx), act, e.val);
        chk($sformatf("latency%0d", idx), cyc, e.cyc);
      end
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    pop_chk(0, dv_a, longint'($signed(dout_a)));
    pop_chk(1, dv_b, longint'($signed(dout_b)));
    pop_chk(2, dv_c, longint'($signed(dout_c)));
  end

  // Drive one cycle of stimulus and advance the reference model
  task automatic step(input bit vld, input bit clr);
    longint             s [3];
    longint             v;
    logic signed [15:0] t16;
    din_valid = vld;
    clear     = clr;
    s = '{0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      din_a[k*16 +: 16] = ch_a[k];
      din_c[k*16 +: 16] = ch_c[k];
      s[0] += ch_a[k];
      s[2] += ch_c[k];
    end
    for (int k = 0; k < 3; k++) begin
      din_b[k*16 +: 16] = ch_b[k];
      s[1] += ch_b[k];
    end
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0;
        m_acc[i] = 0;
      end
      m_ovf = 1'b0;
    end
    if (vld) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] == 0) begin
          m_len[i] = int'(acc_len);
          m_acc[i] = 0;
        end
        m_acc[i] += s[i];
        if (m_cnt[i] == m_len[i]) begin
          v = m_acc[i];
          if (i == 2) begin
`ifdef ADDER_TREE_ACCUM_SAT_EN
            if (v > 32767) begin
              v = 32767;
              m_ovf = 1'b1;
            end else if (v < -32768) begin
              v = -32768;
              m_ovf = 1'b1;
            end
`else
            t16 = v[15:0];
            v   = longint'(t16);
`endif
          end
          push(i, v, cyc + 4);
          m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
        end
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic set_ch(input int c0, input int c1, input int c2, input int c3);
    ch_a[0] = 16'(c0); ch_a[1] = 16'(c1); ch_a[2] = 16'(c2); ch_a[3] = 16'(c3);
    ch_c[0] = 16'(c0); ch_c[1] = 16'(c1); ch_c[2] = 16'(c2); ch_c[3] = 16'(c3);
    ch_b[0] = 16'(c0); ch_b[1] = 16'(c1); ch_b[2] = 16'(c2);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    din_valid = 1'b0;
    acc_len   = 8'd0;
    din_a     = '0;
    din_b     = '0;
    din_c     = '0;
    m_ovf     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_len[i] = 0;
      m_acc[i] = 0;
    end
    set_ch(0, 0, 0, 0);
    @(negedge clk);
    idle(3);
    chk("rst_dout_a", longint'(dout_a), 0);
    chk("rst_dv_a", longint'(dv_a), 0);
    chk("rst_ovf_c", longint'(ovf_c), 0);
    rst = 1'b0;
    idle(2);

    // Single passthrough sample, exact latency and one-cycle strobe
    set_ch(1, 2, 3, 4);
    step(1'b1, 1'b0);
    idle(7);
    chk("hold_dout_a", longint'($signed(dout_a)), 10);
    chk("strobe_low_a", longint'(dv_a), 0);

    // Most negative channels; back-to-back samples through the 3-channel tree
    set_ch(-32768, -32768, -32768, -32768);
    ch_b[0] = 16'sd1; ch_b[1] = 16'sd1; ch_b[2] = 16'sd1;
    step(1'b1, 1'b0);
    set_ch(-32768, -32768, -32768, -32768);
    ch_b[0] = 16'sd2; ch_b[1] = 16'sd2; ch_b[2] = 16'sd2;
    step(1'b1, 1'b0);
    idle(7);
    chk("neg_ovf_a", longint'(ovf_a), 0);

    // Four-sample block with bubbles; acc_len changes mid-block
    acc_len = 8'd3;
    idle(5);
    set_ch(1, 2, 3, 4);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0);
      idle($urandom_range(0, 3));
      if (j == 1) begin
        idle(5);
        acc_len = 8'd1;
      end
    end
    idle(7);
    for (int j = 0; j < 2; j++) begin
      set_ch($urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000,
             $urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000);
      step(1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(7);

    // Aborted partial block, then a full block
    acc_len = 8'd3;
    idle(5);
    set_ch(1, 2, 3, 4);
    repeat (2) step(1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    idle(7);
    chk("blk_dout_a", longint'($signed(dout_a)), 40);

    // Reset in the middle of a block: no output, dout cleared
    repeat (2) step(1'b1, 1'b0);
    idle(5);
    rst = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_acc[i] = 0;
    end
    m_ovf = 1'b0;
    rst = 1'b0;
    chk("midrst_dout_a", longint'(dout_a), 0);
    chk("midrst_dout_c", longint'(dout_c), 0);
    chk("midrst_dv_b", longint'(dv_b), 0);
    idle(8);

    // Full-scale positive channels into the 16-bit output
    acc_len = 8'd0;
    idle(5);
    set_ch(32767, 32767, 32767, 32767);
    step(1'b1, 1'b0);
    idle(7);
    chk("sat_ovf_c", longint'(ovf_c), longint'(m_ovf));
    idle(3);
    chk("sat_ovf_c_sticky", longint'(ovf_c), longint'(m_ovf));
    chk("sat_ovf_a", longint'(ovf_a), 0);
    step(1'b0, 1'b1);
    idle(2);
    chk("clr_ovf_c", longint'(ovf_c), 0);

    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_c_drained", q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
